// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
// Line addresses drop OFFSET_BITS low bits (32-byte lines).
package burst_mem_pkg;

    localparam int OFFSET_BITS       = 5;
    localparam int BURST_LEN_DEFAULT = 4;

    typedef logic [63:0]  beat_t;
    typedef logic [255:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READ_BURST,
        WRITE_BURST,
        DONE
    } burst_state_t;

endpackage

// File: rtl/mem_line_array.sv
// Beat-addressed line storage: one registered read port, one write port.
// Address is {line index, beat}; written so synthesis can map it to block RAM.
module mem_line_array
    import burst_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    // Output register holds between bursts so rdata is stable while resp is low.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/burst_mem_responder.sv
// Responder for the 4-beat burst memory interface with programmable latency.
// Request is held by the initiator; dropping it early aborts the burst and flags an error.
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = BURST_LEN_DEFAULT,
    parameter int NUM_LINES  = 256,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           mem_address,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_resp,
    output logic                  protocol_err
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int LAT_W  = $clog2(LATENCY + 1);

    burst_state_t      state, state_n;
    logic              op_rd;
    logic [IDX_W-1:0]  idx, req_idx, rd_idx;
    logic [BEAT_W-1:0] beat_cnt, rd_beat;
    logic [LAT_W-1:0]  lat_cnt;
    logic              held, accept, set_err, rd_en, we;
    logic              unused_addr;

    assign req_idx     = mem_address[OFFSET_BITS +: IDX_W];
    assign unused_addr = ^{mem_address[31:OFFSET_BITS+IDX_W], mem_address[OFFSET_BITS-1:0]};
    assign held        = op_rd ? mem_read : mem_write;

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        set_err  = 1'b0;
        rd_en    = 1'b0;
        rd_idx   = idx;
        rd_beat  = '0;
        mem_resp = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read | mem_write) begin
                    accept  = 1'b1;
                    set_err = mem_read & mem_write;
                    if (LATENCY == 1)
                        state_n = mem_read ? READ_BURST : WRITE_BURST;
                    else
                        state_n = WAIT;
                end
            end
            WAIT: begin
                if (!held) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end else if (lat_cnt == '0) begin
                    state_n = op_rd ? READ_BURST : WRITE_BURST;
                end
            end
            READ_BURST, WRITE_BURST: begin
                mem_resp = held & ~rst;
                if (!held) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end else if (beat_cnt == BEAT_W'(BURST_LEN - 1)) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // The array read is registered, so fetch the beat due in the next cycle.
        if (state_n == READ_BURST) begin
            rd_en   = 1'b1;
            rd_idx  = (state == IDLE) ? req_idx : idx;
            rd_beat = (state == READ_BURST) ? beat_cnt + BEAT_W'(1) : '0;
        end
    end

    assign we = (state == WRITE_BURST) && mem_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_rd        <= 1'b0;
            idx          <= '0;
            beat_cnt     <= '0;
            lat_cnt      <= '0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_n;
            if (set_err)
                protocol_err <= 1'b1;
            if (accept) begin
                op_rd    <= mem_read;
                idx      <= req_idx;
                beat_cnt <= '0;
                lat_cnt  <= LAT_W'(LATENCY > 1 ? LATENCY - 2 : 0);
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (mem_resp)
                beat_cnt <= beat_cnt + BEAT_W'(1);
        end
    end

    mem_line_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (IDX_W + BEAT_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en),
        .rd_addr ({rd_idx, rd_beat}),
        .rd_data (mem_rdata),
        .we      (we),
        .wr_addr ({idx, beat_cnt}),
        .wr_data (mem_wdata)
    );

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed plus randomized bursts against two responders (latency 4 and 1),
// checked against a line-array model and arithmetic resp timing.
module tb_burst_mem_responder;
    import burst_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd, req_wr;
    logic [31:0] addr;
    beat_t       wdata;
    bit          sel;

    logic  rd0, wr0, rd1, wr1, resp0, resp1, err0, err1, resp, err;
    beat_t rdata0, rdata1, rdata;

    assign rd0   = req_rd & ~sel;
    assign wr0   = req_wr & ~sel;
    assign rd1   = req_rd & sel;
    assign wr1   = req_wr & sel;
    assign resp  = sel ? resp1 : resp0;
    assign err   = sel ? err1 : err0;
    assign rdata = sel ? rdata1 : rdata0;

    always #5 clk = ~clk;

    burst_mem_responder #(.DATA_WIDTH(64), .BURST_LEN(4), .NUM_LINES(256), .LATENCY(4)) u_dut0 (
        .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .mem_address(addr),
        .mem_wdata(wdata), .mem_rdata(rdata0), .mem_resp(resp0), .protocol_err(err0)
    );

    burst_mem_responder #(.DATA_WIDTH(64), .BURST_LEN(4), .NUM_LINES(256), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .mem_address(addr),
        .mem_wdata(wdata), .mem_rdata(rdata1), .mem_resp(resp1), .protocol_err(err1)
    );

    beat_t model [2][256][4];
    bit    exp_err [2];
    int    vectors = 0;
    int    miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_rd = 1'b0;
            req_wr = 1'b0;
            @(negedge clk);
            check("idle_resp", resp, 0);
            step();
        end
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++)
            l[32*i +: 32] = $urandom();
        return l;
    endfunction

    // pre: cycles the request is already high before the accepting cycle (0).
    // stop_at: beats served before the request drops (4 = full burst); do_rst pulses
    // reset in the drop cycle.
    task automatic burst(input bit is_rd, input bit both, input logic [31:0] a, input line_t line,
                         input int pre, input int stop_at, input bit do_rst);
        int lat, ix, endc, k;
        bit drop, exp_resp;
        lat  = sel ? 1 : 4;
        ix   = int'((a >> 5) & 32'hFF);
        endc = (stop_at < 4) ? lat + stop_at : lat + 3;
        for (int c = -pre; c <= endc; c++) begin
            drop   = (stop_at < 4) && (c == endc);
            req_rd = !drop && (is_rd || both);
            req_wr = !drop && (!is_rd || both);
            addr   = (c == 0) ? a : $urandom();
            k      = (c < lat) ? 0 : c - lat;
            wdata  = line[64*k +: 64];
            rst    = do_rst && drop;
            @(negedge clk);
            exp_resp = !drop && (c >= lat);
            check("resp", resp, 64'(exp_resp));
            if (exp_resp && is_rd)
                check("rdata", rdata, model[sel][ix][k]);
            if (exp_resp && !is_rd)
                model[sel][ix][k] = wdata;
            step();
        end
        req_rd = 1'b0;
        req_wr = 1'b0;
        rst    = 1'b0;
        if (do_rst) begin
            exp_err[0] = 1'b0;
            exp_err[1] = 1'b0;
        end else if (both || stop_at < 4) begin
            exp_err[sel] = 1'b1;
        end
        check("protocol_err", err, 64'(exp_err[sel]));
    endtask

    initial begin
        line_t l;
        logic [31:0] a;
        int gap, ix;
        bit rd;

        rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++)
                for (int b = 0; b < 4; b++)
                    model[s][i][b] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_resp0", resp0, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_err0", err0, 0);
        check("rst_resp1", resp1, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_err1", err1, 0);
        step();

        // Write then read line 0x80 at latency 4.
        l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        burst(0, 0, 32'h80, l, 0, 4, 0);
        idle(2);
        burst(1, 0, 32'h80, '0, 0, 4, 0);
        idle(1);
        check("beat0_const", model[0][4][0], 64'h1111_1111_1111_1111);

        // Back-to-back reads: second request raised during DONE.
        burst(0, 0, 32'h20, rand_line(), 0, 4, 0);
        idle(1);
        burst(1, 0, 32'h20, '0, 0, 4, 0);
        burst(1, 0, 32'h20, '0, 1, 4, 0);
        idle(2);

        // Address aliasing on index bits.
        burst(0, 0, 32'h0000_2040, rand_line(), 0, 4, 0);
        idle(1);
        burst(1, 0, 32'h0000_0040, '0, 0, 4, 0);
        idle(1);
        burst(1, 0, 32'h0000_0047, '0, 0, 4, 0);
        idle(1);

        // Prefill lines 0..7 on both responders.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 8; i++) begin
                burst(0, 0, 32'(i << 5), rand_line(), 0, 4, 0);
                idle(1);
            end
        end

        // Latency 1: write, read, back-to-back read.
        sel = 1'b1;
        burst(0, 0, 32'h80, rand_line(), 0, 4, 0);
        idle(1);
        burst(1, 0, 32'h80, '0, 0, 4, 0);
        burst(1, 0, 32'h60, '0, 1, 4, 0);
        idle(2);

        // Protocol violations on the latency-4 responder.
        sel = 1'b0;
        burst(1, 1, 32'h80, '0, 0, 4, 0);
        idle(2);
        burst(1, 0, 32'h20, '0, 0, 2, 0);
        idle(3);
        burst(1, 0, 32'h20, '0, 0, 4, 0);
        idle(1);
        burst(0, 0, 32'h40, rand_line(), 0, -2, 0);
        idle(2);
        burst(1, 0, 32'h40, '0, 0, 4, 0);
        idle(1);

        // Reset in the middle of a write burst keeps captured beats.
        burst(0, 0, 32'h80, rand_line(), 0, 2, 1);
        idle(2);
        burst(1, 0, 32'h80, '0, 0, 4, 0);
        idle(1);

        // Randomized traffic over lines 0..7 with wrapping upper address bits.
        for (int n = 0; n < 40; n++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                idle(gap);
                sel = $urandom_range(0, 1) == 1;
            end
            ix = $urandom_range(0, 7);
            a  = ($urandom() & ~32'h1FE0) | 32'(ix << 5);
            rd = $urandom_range(0, 1) == 1;
            burst(rd, 0, a, rand_line(), (gap == 0) ? 1 : 0, 4, 0);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
